noise_stim_ctrl: RTL and testbench

//  Sequencer for the LFSR noise source feeding the FIR low-pass datapath under test.
//  - On i_start, steps the LFSR once per sample tick through four amplitude levels:
//    12, 16, 18, then 24 active bits.
//  - Emits each captured noise word on a valid/ready stream toward the FIR input.
//  - Pulses o_done after the last sample of the last level.

---
 rtl/noise_pkg.sv | 32 +++
 rtl/sample_tick_gen.sv | 59 +++++
 rtl/noise_stim_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_noise_stim_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// -----------------------------------------------------------------------------
// noise_pkg
// Shared types and constants for the LFSR noise stimulus sequencer.
//   stim_state_e : sequencer states (IDLE, WAIT, STEP, LOAD, VALID, DONE)
//   NUM_LEVELS   : number of amplitude levels walked per sequence
//   LAST_LEVEL   : index of the final level
//   LEVEL_SEL    : level index -> LFSR width select
//                  (level 0..3 = 12/16/18/24 active bits = sel 1/2/3/0)
// -----------------------------------------------------------------------------
package noise_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    STEP  = 3'd2,
    LOAD  = 3'd3,
    VALID = 3'd4,
    DONE  = 3'd5
  } stim_state_e;

  localparam int NUM_LEVELS = 4;

  localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);

  localparam logic [1:0] LEVEL_SEL [NUM_LEVELS] = '{2'd1, 2'd2, 2'd3, 2'd0};

  // Width select driven to the LFSR for a given amplitude level.
  function automatic logic [1:0] level_to_sel(input logic [1:0] level);
    return LEVEL_SEL[level];
  endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// -----------------------------------------------------------------------------
// sample_tick_gen
// Sample-rate divider. Counts cycles while enabled and flags the cycle in
// which the count equals the divider value D, so an enabled run of D+1
// cycles ends in exactly one tick. The count restarts from zero after a tick
// and whenever the sequencer clears it, so it never wraps.
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_clr    synchronous clear of the cycle count (priority over i_en)
//   i_en     count enable
//   i_div    divider value D (held stable by the sequencer for a run)
//   o_tick   high while enabled and count == D
// -----------------------------------------------------------------------------
module sample_tick_gen #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic [DIV_WIDTH-1:0] i_div,
  output logic                 o_tick
);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = {{(DIV_WIDTH-1){1'b0}}, 1'b1};

  logic [DIV_WIDTH-1:0] div_cnt_d;
  logic [DIV_WIDTH-1:0] div_cnt_q;

  assign o_tick = i_en && (div_cnt_q == i_div);

  // Next cycle count: clear, restart after the tick, advance, or hold.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (i_clr) begin
      div_cnt_d = DIV_ZERO;
    end else if (i_en) begin
      if (o_tick) begin
        div_cnt_d = DIV_ZERO;
      end else begin
        div_cnt_d = div_cnt_q + DIV_ONE;
      end
    end else begin
      div_cnt_d = div_cnt_q;
    end
  end

  // Cycle count register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      div_cnt_q <= DIV_ZERO;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/noise_stim_ctrl.sv
// -----------------------------------------------------------------------------
// noise_stim_ctrl
// Sequencer for the LFSR noise source feeding the FIR low-pass datapath.
// On a start request it walks four amplitude levels (12, 16, 18, 24 active
// bits), stepping the external LFSR once per sample tick, capturing each
// post-step noise word and offering it on a valid/ready stream. A one-cycle
// done pulse marks the end of the last sample of the last level.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_start          start request (honoured only when idle)
//   i_abort          abort, priority over everything; returns to idle
//   i_div            divider D, latched at start (D+1 wait cycles per sample)
//   i_burst_len      samples per level N, latched at start (0 acts as 1)
//   o_lfsr_en        one-cycle LFSR advance enable
//   o_lfsr_sel       LFSR width select for the current level
//   i_noise          LFSR output word
//   o_sample         captured noise sample, held until accepted
//   o_valid, i_ready output stream handshake
//   o_level          current level index 0..3
//   o_busy           high whenever not idle
//   o_done           one-cycle completion pulse
// All outputs are registers loaded from a decode of the next state, so they
// change on the same edge as the state they describe.
// -----------------------------------------------------------------------------
module noise_stim_ctrl
  import noise_pkg::*;
#(
  parameter int LFSR_WIDTH = 24,
  parameter int DIV_WIDTH  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [DIV_WIDTH-1:0]  i_div,
  input  logic [CNT_WIDTH-1:0]  i_burst_len,
  output logic                  o_lfsr_en,
  output logic [1:0]            o_lfsr_sel,
  input  logic [LFSR_WIDTH-1:0] i_noise,
  output logic [LFSR_WIDTH-1:0] o_sample,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [1:0]            o_level,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};
  localparam logic [LFSR_WIDTH-1:0] SMP_ZERO = {LFSR_WIDTH{1'b0}};

  stim_state_e           state_d, state_q;
  logic [DIV_WIDTH-1:0]  div_d, div_q;
  // Index of the last sample in a level (N-1, with N=0 folded onto N=1).
  logic [CNT_WIDTH-1:0]  last_idx_d, last_idx_q;
  logic [CNT_WIDTH-1:0]  sample_cnt_d, sample_cnt_q;
  logic [1:0]            level_d, level_q;
  logic [LFSR_WIDTH-1:0] sample_d, sample_q;
  logic                  lfsr_en_d, lfsr_en_q;
  logic [1:0]            lfsr_sel_d, lfsr_sel_q;
  logic                  valid_d, valid_q;
  logic                  busy_d, busy_q;
  logic                  done_d, done_q;

  logic                  tick_s;
  logic                  in_wait_s;

  assign in_wait_s = (state_q == WAIT);

  // The divider only runs in WAIT; every other state (including VALID while
  // stalled) holds it cleared, so backpressure cannot consume a tick.
  sample_tick_gen #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_tick_gen (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (!in_wait_s),
    .i_en    (in_wait_s),
    .i_div   (div_q),
    .o_tick  (tick_s)
  );

  // Next-state and datapath-update logic for the sequencer.
  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    last_idx_d   = last_idx_q;
    level_d      = level_q;
    sample_cnt_d = sample_cnt_q;
    sample_d     = sample_q;
    if (i_abort) begin
      // o_sample deliberately keeps its last value on abort.
      state_d      = IDLE;
      level_d      = 2'd0;
      sample_cnt_d = CNT_ZERO;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_start) begin
            div_d        = i_div;
            if (i_burst_len == CNT_ZERO) begin
              last_idx_d = CNT_ZERO;
            end else begin
              last_idx_d = i_burst_len - CNT_ONE;
            end
            level_d      = 2'd0;
            sample_cnt_d = CNT_ZERO;
            state_d      = WAIT;
          end else begin
            state_d = IDLE;
          end
        end
        WAIT: begin
          if (tick_s) begin
            state_d = STEP;
          end else begin
            state_d = WAIT;
          end
        end
        STEP: begin
          state_d = LOAD;
        end
        LOAD: begin
          // The LFSR advanced on the edge that left STEP, so this is the new word.
          sample_d = i_noise;
          state_d  = VALID;
        end
        VALID: begin
          if (i_ready) begin
            if (sample_cnt_q == last_idx_q) begin
              sample_cnt_d = CNT_ZERO;
              if (level_q == LAST_LEVEL) begin
                state_d = DONE;
              end else begin
                level_d = level_q + 2'd1;
                state_d = WAIT;
              end
            end else begin
              sample_cnt_d = sample_cnt_q + CNT_ONE;
              state_d      = WAIT;
            end
          end else begin
            state_d = VALID;
          end
        end
        DONE: begin
          level_d = 2'd0;
          state_d = IDLE;
        end
        default: begin
          level_d      = 2'd0;
          sample_cnt_d = CNT_ZERO;
          state_d      = IDLE;
        end
      endcase
    end
  end

  // Moore decode of the next state into the registered outputs.
  always_comb begin
    lfsr_en_d = (state_d == STEP);
    valid_d   = (state_d == VALID);
    busy_d    = (state_d != IDLE);
    done_d    = (state_d == DONE);
    if (state_d == IDLE) begin
      lfsr_sel_d = 2'd0;
    end else begin
      lfsr_sel_d = level_to_sel(level_d);
    end
  end

  // Sequencer state, latched run parameters and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      div_q        <= DIV_ZERO;
      last_idx_q   <= CNT_ZERO;
      sample_cnt_q <= CNT_ZERO;
      level_q      <= 2'd0;
      sample_q     <= SMP_ZERO;
      lfsr_en_q    <= 1'b0;
      lfsr_sel_q   <= 2'd0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      last_idx_q   <= last_idx_d;
      sample_cnt_q <= sample_cnt_d;
      level_q      <= level_d;
      sample_q     <= sample_d;
      lfsr_en_q    <= lfsr_en_d;
      lfsr_sel_q   <= lfsr_sel_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign o_lfsr_en  = lfsr_en_q;
  assign o_lfsr_sel = lfsr_sel_q;
  assign o_sample   = sample_q;
  assign o_valid    = valid_q;
  assign o_level    = level_q;
  assign o_busy     = busy_q;
  assign o_done     = done_q;

endmodule

// File: tb/tb_noise_stim_ctrl.sv
// -----------------------------------------------------------------------------
// tb_noise_stim_ctrl
// Bench for noise_stim_ctrl. A behavioural 24-bit LFSR stands in for the
// external noise source (advances on o_lfsr_en, output masked by o_lfsr_sel).
// Each start pushes the whole expected sample sequence into a scoreboard;
// a monitor pops and compares on every accepted output word.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_noise_stim_ctrl;

  localparam int LW = 24;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam logic [23:0] SEED = 24'h5A3C71;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          ready = 1'b0;
  logic [DW-1:0] div   = '0;
  logic [CW-1:0] blen  = '0;
  logic          lfsr_en;
  logic [1:0]    lfsr_sel;
  logic [LW-1:0] noise;
  logic [LW-1:0] sample;
  logic          valid;
  logic          busy;
  logic          done;
  logic [1:0]    level;

  always #5 clk = ~clk;

  noise_stim_ctrl #(.LFSR_WIDTH(LW), .DIV_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_div(div), .i_burst_len(blen), .o_lfsr_en(lfsr_en), .o_lfsr_sel(lfsr_sel),
    .i_noise(noise), .o_sample(sample), .o_valid(valid), .i_ready(ready),
    .o_level(level), .o_busy(busy), .o_done(done)
  );

  function automatic logic [23:0] lfsr_step(input logic [23:0] s);
    return {s[22:0], s[23] ^ s[22] ^ s[21] ^ s[16]};
  endfunction

  function automatic logic [23:0] sel_mask(input logic [1:0] sel);
    case (sel)
      2'd1:    return 24'h000FFF;
      2'd2:    return 24'h00FFFF;
      2'd3:    return 24'h03FFFF;
      default: return 24'hFFFFFF;
    endcase
  endfunction

  // Stand-in for the external LFSR instance.
  logic [23:0] hw_lfsr = SEED;
  always @(posedge clk) if (lfsr_en) hw_lfsr <= lfsr_step(hw_lfsr);
  assign noise = hw_lfsr & sel_mask(lfsr_sel);

  // Reference model and scoreboard.
  typedef struct packed {
    logic [23:0] smp;
    logic [1:0]  lvl;
    logic [1:0]  sel;
    logic [23:0] st;
  } exp_t;

  exp_t        sb_q[$];
  logic [23:0] ref_state = SEED;
  logic [23:0] ref_start = SEED;
  int          widths[4] = '{12, 16, 18, 24};

  int n_vec = 0;
  int n_err = 0;
  int cyc_n = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int xfer_cnt = 0;
  int xfer_cyc[$];
  bit rand_rdy = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_sequence(input int n);
    int n_eff;
    exp_t e;
    logic [24:0] m;
    n_eff = (n == 0) ? 1 : n;
    ref_start = ref_state;
    for (int l = 0; l < 4; l++) begin
      for (int s = 0; s < n_eff; s++) begin
        ref_state = lfsr_step(ref_state);
        m = (25'd1 << widths[l]) - 25'd1;
        e.smp = ref_state & m[23:0];
        e.lvl = 2'(l);
        e.sel = 2'((l + 1) % 4);
        e.st  = ref_state;
        sb_q.push_back(e);
      end
    end
  endtask

  // Monitor: counts strobes, checks stall stability, pops scoreboard on transfer.
  initial begin : monitor
    exp_t        e;
    logic        prev_valid;
    logic        prev_xfer;
    logic [23:0] prev_sample;
    prev_valid  = 1'b0;
    prev_xfer   = 1'b0;
    prev_sample = '0;
    forever begin
      @(negedge clk);
      cyc_n++;
      if (lfsr_en) en_cnt++;
      if (done) done_cnt++;
      if (valid && prev_valid && !prev_xfer) chk("hold_sample", 32'(sample), 32'(prev_sample));
      if (valid && ready) begin
        if (sb_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_xfer: got sample %0h expected no output", sample);
        end else begin
          e = sb_q.pop_front();
          chk("sample", 32'(sample), 32'(e.smp));
          chk("level", 32'(level), 32'(e.lvl));
          chk("sel", 32'(lfsr_sel), 32'(e.sel));
        end
        xfer_cnt++;
        xfer_cyc.push_back(cyc_n);
      end
      prev_valid  = valid;
      prev_xfer   = valid && ready;
      prev_sample = sample;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
    if (rand_rdy) ready = 1'($urandom_range(0, 1));
  endtask

  task automatic kick(input int d, input int n);
    div   = DW'(d);
    blen  = CW'(n);
    start = 1'b1;
    push_sequence(n);
    cyc();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k;
    k = 0;
    while (busy && k < budget) begin
      cyc();
      k++;
    end
    chk(name, 32'(busy), 32'd0);
  endtask

  initial begin : stim
    int k, e0, d0, x0, c0;
    logic [23:0] s0;
    int d, n;

    // Reset state
    rst_n = 1'b0;
    cyc();
    cyc();
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_en", 32'(lfsr_en), 32'd0);
    chk("rst_sel", 32'(lfsr_sel), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    rst_n = 1'b1;
    cyc();

    // 1: D=2, N=3, ready high
    ready = 1'b1;
    e0 = en_cnt; d0 = done_cnt; x0 = xfer_cnt;
    kick(2, 3);
    k = 0;
    while (!valid && k < 20) begin cyc(); k++; end
    chk("t1_latency", 32'(k), 32'd5);
    wait_idle(300, "t1_timeout");
    chk("t1_steps", 32'(en_cnt - e0), 32'd12);
    chk("t1_done", 32'(done_cnt - d0), 32'd1);
    chk("t1_xfers", 32'(xfer_cnt - x0), 32'd12);
    chk("t1_sb_empty", 32'(sb_q.size()), 32'd0);

    // 2: D=0, N=1, sample every 4 cycles
    c0 = xfer_cyc.size(); d0 = done_cnt;
    kick(0, 1);
    wait_idle(100, "t2_timeout");
    chk("t2_xfers", 32'(xfer_cyc.size() - c0), 32'd4);
    for (int i = 1; i < 4 && (c0 + i) < xfer_cyc.size(); i++)
      chk("t2_period", 32'(xfer_cyc[c0 + i] - xfer_cyc[c0 + i - 1]), 32'd4);
    chk("t2_done", 32'(done_cnt - d0), 32'd1);

    // 3: backpressure, D=1, N=2
    ready = 1'b0;
    kick(1, 2);
    k = 0;
    while (!valid && k < 20) begin cyc(); k++; end
    chk("t3_valid_seen", 32'(valid), 32'd1);
    s0 = sample;
    e0 = en_cnt;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("t3_stable", 32'(sample), 32'(s0));
      chk("t3_en_low", 32'(lfsr_en), 32'd0);
    end
    chk("t3_no_step", 32'(en_cnt - e0), 32'd0);
    ready = 1'b1;
    cyc();
    chk("t3_after_xfer", 32'(valid), 32'd0);
    k = 0;
    while (!valid && k < 20) begin cyc(); k++; end
    chk("t3_next_valid", 32'(k), 32'd4);
    wait_idle(200, "t3_timeout");
    chk("t3_sb_empty", 32'(sb_q.size()), 32'd0);

    // 4: abort during level-2 VALID, then restart
    ready = 1'b1;
    kick(1, 2);
    k = 0;
    while (!(valid && level == 2'd2) && k < 200) begin cyc(); k++; end
    abort = 1'b1;
    ready = 1'b0;
    chk("t4_reached", 32'(valid && level == 2'd2), 32'd1);
    s0 = '0;
    if (sb_q.size() > 0) begin
      s0 = sb_q[0].smp;
      ref_state = sb_q[0].st;
      chk("t4_front_sample", 32'(sample), 32'(s0));
    end
    d0 = done_cnt;
    cyc();
    abort = 1'b0;
    ready = 1'b1;
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_valid", 32'(valid), 32'd0);
    chk("t4_en", 32'(lfsr_en), 32'd0);
    chk("t4_sample_kept", 32'(sample), 32'(s0));
    cyc();
    cyc();
    chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
    sb_q.delete();
    // start and abort together while idle: stays idle
    start = 1'b1;
    abort = 1'b1;
    cyc();
    start = 1'b0;
    abort = 1'b0;
    chk("t4_start_abort_idle", 32'(busy), 32'd0);
    kick(1, 2);
    chk("t4_restart_level", 32'(level), 32'd0);
    chk("t4_restart_sel", 32'(lfsr_sel), 32'd1);
    wait_idle(300, "t4_timeout");
    chk("t4_sb_empty", 32'(sb_q.size()), 32'd0);

    // 5: N=0 behaves as N=1; start and parameter changes mid-run ignored
    e0 = en_cnt; d0 = done_cnt; x0 = xfer_cnt; c0 = xfer_cyc.size();
    kick(1, 0);
    for (int i = 0; i < 6; i++) cyc();
    start = 1'b1; div = 16'd7; blen = 16'd9;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    wait_idle(300, "t5_timeout");
    chk("t5_xfers", 32'(xfer_cnt - x0), 32'd4);
    chk("t5_steps", 32'(en_cnt - e0), 32'd4);
    chk("t5_done", 32'(done_cnt - d0), 32'd1);
    for (int i = 1; i < 4 && (c0 + i) < xfer_cyc.size(); i++)
      chk("t5_period", 32'(xfer_cyc[c0 + i] - xfer_cyc[c0 + i - 1]), 32'd5);
    cyc();
    chk("t5_idle_after", 32'(busy), 32'd0);

    // 6: asynchronous reset mid-WAIT
    kick(5, 1);
    cyc();
    cyc();
    cyc();
    chk("t6_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_sel", 32'(lfsr_sel), 32'd0);
    chk("t6_level", 32'(level), 32'd0);
    chk("t6_sample", 32'(sample), 32'd0);
    chk("t6_valid", 32'(valid), 32'd0);
    sb_q.delete();
    ref_state = ref_start;
    cyc();
    rst_n = 1'b1;
    cyc();
    cyc();
    chk("t6_idle", 32'(busy), 32'd0);

    // 7: randomized runs with random backpressure
    rand_rdy = 1'b1;
    for (int r = 0; r < 5; r++) begin
      d = $urandom_range(0, 3);
      n = $urandom_range(0, 3);
      d0 = done_cnt; x0 = xfer_cnt;
      kick(d, n);
      wait_idle(3000, "t7_timeout");
      chk("t7_done", 32'(done_cnt - d0), 32'd1);
      chk("t7_xfers", 32'(xfer_cnt - x0), 32'(4 * ((n == 0) ? 1 : n)));
      chk("t7_sb_empty", 32'(sb_q.size()), 32'd0);
    end
    rand_rdy = 1'b0;
    ready = 1'b1;
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
